// File: rtl/hadamard_pkg.sv
// hadamard_pkg: shared widths and index helpers
// for the N-point Walsh-Hadamard pipeline.
package hadamard_pkg;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int ow_w(input int dw,
                              input int log2n);
    return dw + log2n;
  endfunction

  function automatic int stage_ow(input int dw,
                                  input int s);
    return dw + s + 1;
  endfunction

  function automatic int pair_idx(input int i,
                                  input int s);
    return i ^ (1 << s);
  endfunction

  // Offset of stage s input lanes in the
  // packed inter-stage bus (widths grow by
  // one bit per stage).
  function automatic int stage_base(input int n,
                                    input int dw,
                                    input int s);
    return n * (s * dw + (s * (s - 1)) / 2);
  endfunction

endpackage

// File: rtl/hadamard_stage.sv
// hadamard_stage: one registered butterfly
// layer pairing lanes i and i^(1<<S).
module hadamard_stage
  import hadamard_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 8,
  parameter int S  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              v_in,
  input  logic [N*IW-1:0]   a,
  output logic              v_out,
  output logic [N*(IW+1)-1:0] b
);

  localparam int BW = IW + 1;

  logic [N*BW-1:0] sum;

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int J = pair_idx(i, S);
    logic signed [BW-1:0] ai;
    logic signed [BW-1:0] aj;
    assign ai = {a[i*IW+IW-1], a[i*IW +: IW]};
    assign aj = {a[J*IW+IW-1], a[J*IW +: IW]};
    if (((i >> S) & 1) == 0) begin : g_sum
      assign sum[i*BW +: BW] = ai + aj;
    end else begin : g_dif
      assign sum[i*BW +: BW] = aj - ai;
    end
  end

  // valid bit: cleared on reset, moves with the pipeline
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  v_out <= 1'b0;
    else if (en) v_out <= v_in;

  // data: no reset, loads on every advance
  always_ff @(posedge clk)
    if (en) b <= sum;

endmodule

// File: rtl/hadamard_npt.sv
// hadamard_npt: pipelined N-point Walsh-Hadamard
// transform with valid/ready stream handshake.
module hadamard_npt
  import hadamard_pkg::*;
#(
  parameter int LOG2N = 2,
  parameter int DW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [(1<<LOG2N)*DW-1:0] x_in,
  output logic out_valid,
  input  logic out_ready,
  output logic [(1<<LOG2N)*(DW+LOG2N)-1:0] y_out
);

  localparam int N    = 1 << LOG2N;
  localparam int OW   = ow_w(DW, LOG2N);
  localparam int BUSW = stage_base(N, DW, LOG2N + 1);
  localparam int YB   = stage_base(N, DW, LOG2N);

  logic             adv;
  logic [LOG2N:0]   v;
  logic [BUSW-1:0]  bus;

  // whole pipe moves unless the output is stalled
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign v[0]           = in_valid;
  assign bus[N*DW-1:0]  = x_in;

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int IW = DW + s;
    localparam int IB = stage_base(N, DW, s);
    localparam int OB = stage_base(N, DW, s + 1);
    hadamard_stage #(
      .N  (N),
      .IW (IW),
      .S  (s)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .v_in  (v[s]),
      .a     (bus[IB +: N*IW]),
      .v_out (v[s+1]),
      .b     (bus[OB +: N*(IW+1)])
    );
  end

  assign out_valid = v[LOG2N];
  assign y_out     = bus[YB +: N*OW];

endmodule

// File: tb/tb_hadamard_npt.sv
// tb_hadamard_npt: directed and scoreboard checks
// for hadamard_npt across several sizes.
module tb_hadamard_npt;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] y_out;

  int n_chk;
  int n_err;
  int rx;
  bit sweep_go;
  int sweep_done;

  hadamard_npt #(.LOG2N(2), .DW(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  function automatic void wht(input int n,
                              input int x[64],
                              output int y[64]);
    for (int k = 0; k < 64; k++) begin
      y[k] = 0;
      if (k < n)
        for (int i = 0; i < n; i++)
          y[k] += ($countones(i & k) % 2 == 1) ?
                  -x[i] : x[i];
    end
  endfunction

  function automatic logic [31:0] px(input int a,
    input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [39:0] py(input int a,
    input int b, input int c, input int d);
    return {d[9:0], c[9:0], b[9:0], a[9:0]};
  endfunction

  function automatic logic [39:0] model4(
    input logic [31:0] x);
    int xi[64];
    int yi[64];
    for (int i = 0; i < 64; i++) xi[i] = 0;
    for (int i = 0; i < 4; i++)
      xi[i] = int'($signed(x[i*8 +: 8]));
    wht(4, xi, yi);
    return py(yi[0], yi[1], yi[2], yi[3]);
  endfunction

  // scoreboard / protocol monitor at negedge
  initial begin
    logic [39:0] sb[$];
    logic [39:0] y_hold;
    bit          stl;
    stl = 0;
    y_hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        stl = 0;
      end else begin
        chk("in_ready", in_ready,
            !(out_valid && !out_ready));
        if (stl) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_hold", y_out, y_hold);
        end
        stl    = out_valid && !out_ready;
        y_hold = y_out;
        if (in_valid && in_ready)
          sb.push_back(model4(x_in));
        if (out_valid && out_ready) begin
          if (sb.size() == 0)
            chk("spurious_out", 1, 0);
          else begin
            chk("sb_y", y_out, sb.pop_front());
            rx++;
          end
        end
      end
    end
  end

  task automatic dir(input string tag,
                     input logic [31:0] x,
                     input logic [39:0] y);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_y"}, y_out, y);
    @(negedge clk);
    chk({tag, "_once"}, out_valid, 0);
  endtask

  // size sweep: one instance per configuration
  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int L  = (g / 2 == 0) ? 1 :
                        (g / 2 == 1) ? 3 : 6;
    localparam int D  = (g % 2 == 1) ? 16 : 4;
    localparam int NN = 1 << L;
    localparam int O  = D + L;
    logic            iv;
    logic            ir;
    logic            ov;
    logic            ordy;
    logic [NN*D-1:0] xi;
    logic [NN*O-1:0] yo;

    hadamard_npt #(.LOG2N(L), .DW(D)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .x_in      (xi),
      .out_valid (ov),
      .out_ready (ordy),
      .y_out     (yo)
    );

    initial begin
      int xv[64];
      int ev[64];
      int n;
      iv   = 1'b0;
      ordy = 1'b1;
      xi   = '0;
      wait (sweep_go);
      for (int t = 0; t < 3; t++) begin
        for (int i = 0; i < 64; i++) begin
          xv[i] = 0;
          ev[i] = 0;
        end
        if (t == 0) begin
          if (L == 1) begin
            xv[0] = 5;  xv[1] = -3;
            ev[0] = 2;  ev[1] = 8;
          end else begin
            for (int i = 0; i < NN; i++) xv[i] = 1;
            ev[0] = NN;
          end
        end else if (t == 1) begin
          for (int i = 0; i < NN; i++)
            xv[i] = int'($urandom_range(0, (1 << D) - 1))
                    - (1 << (D - 1));
          wht(NN, xv, ev);
        end else begin
          for (int i = 0; i < NN; i++)
            xv[i] = -(1 << (D - 1));
          ev[0] = -NN * (1 << (D - 1));
        end
        for (int i = 0; i < NN; i++)
          xi[i*D +: D] = xv[i][D-1:0];
        @(posedge clk); #1;
        iv = 1'b1;
        chk($sformatf("sw%0d_ir", g), ir, 1);
        @(posedge clk); #1;
        iv = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!ov && n < 20);
        chk($sformatf("sw%0d_t%0d_lat", g, t), n, L);
        for (int k = 0; k < NN; k++)
          chk($sformatf("sw%0d_t%0d_y%0d", g, t, k),
              int'($signed(yo[k*O +: O])), ev[k]);
        @(negedge clk);
        chk($sformatf("sw%0d_t%0d_once", g, t), ov, 0);
      end
      sweep_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int sent;
    int guard;
    bit acc;
    n_chk      = 0;
    n_err      = 0;
    rx         = 0;
    sweep_go   = 0;
    sweep_done = 0;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    x_in       = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_irdy", in_ready, 1);
    rst_n = 1'b1;

    dir("basic", px(1, 2, 3, 4), py(10, -2, -4, 0));
    dir("min", px(-128, -128, -128, -128),
        py(-512, 0, 0, 0));
    dir("alt", px(127, -128, 127, -128),
        py(-2, 510, 0, 0));

    // streaming: back-to-back, one result per cycle
    r0 = rx;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      x_in     = $urandom();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("stream_cnt", rx - r0, 100);
    repeat (3) @(negedge clk);

    // backpressure: random out_ready, in_valid held
    r0    = rx;
    sent  = 0;
    guard = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    x_in     = $urandom();
    while (sent < 60 && guard < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        sent++;
        x_in = $urandom();
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", sent, 60);
    repeat (6) @(negedge clk);
    #1;
    chk("bp_cnt", rx - r0, 60);

    // reset with two vectors in flight
    @(posedge clk); #1;
    in_valid = 1'b1;
    x_in     = px(1, 1, 1, 1);
    @(posedge clk); #1;
    x_in     = px(2, 2, 2, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_pre_ov", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_irdy", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_idle_ov", out_valid, 0);
    dir("after_rst", px(3, -1, 4, -2),
        py(4, 10, 0, -2));

    sweep_go = 1;
    wait (sweep_done == 6);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hadamard_npt.md
# hadamard_npt

Parametrised, fully pipelined N-point Walsh–Hadamard transform (natural/Sylvester order, N = 2^LOG2N) with a valid/ready stream interface. It generalises the fixed 4-point, 8-bit transform to any power-of-two size and sample width, and adds reset, valid tracking and output backpressure. It sits between the sample-vector source and any downstream consumer that accepts one transformed vector per cycle.

## Interface
- LOG2N, default 2: log2 of transform size; N = 2^LOG2N, legal range 1..6.
- DW, default 8: signed input sample width.
- OW, derived: output width, DW + LOG2N. Not overridable.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  x_in holds a valid vector.
- in_ready  out  1  block accepts x_in this cycle.
- x_in  in  N*DW  signed samples; x[i] = x_in[i*DW +: DW].
- out_valid  out  1  y_out holds a valid transformed vector.
- out_ready  in  1  consumer accepts y_out this cycle.
- y_out  out  N*OW  signed results; y[k] = y_out[k*OW +: OW].

## Operation
- y[k] = sum over i of (-1)^popcount(i & k) * x[i]; natural order, no normalisation, no rounding.
- LOG2N registered butterfly stages. Stage s (0..LOG2N-1) has inputs a[] of width DW+s and outputs b[] of width DW+s+1.
  - For each i with bit s clear, j = i | (1<<s): b[i] = a[i] + a[j], b[j] = a[i] - a[j].
  - Operands are sign-extended one bit before add/sub. Overflow is impossible by construction.
- Each stage has a valid bit v[s].
- Global advance: adv = out_ready | ~out_valid. in_ready = adv.
  - When adv = 1, every stage register and valid bit loads from its predecessor; stage 0 valid loads in_valid.
  - When adv = 0, all stages hold.
- Data registers load on adv regardless of valid and are not reset. Bubbles are not collapsed.
- out_valid = v[LOG2N-1]; y_out = last-stage data.
- Reset: all v[s] clear asynchronously, so out_valid = 0 and in_ready = 1 from reset assertion. y_out is undefined until the first out_valid.
- Reset mid-operation discards every in-flight vector; the first vector accepted after release is the first one produced.

## Timing
- Latency: vector accepted at edge t appears with out_valid = 1 after edge t+LOG2N-1, i.e. LOG2N registers, given no stall.
- Throughput: one vector per cycle while out_ready = 1.
- Stalls:
  - While out_valid & ~out_ready, y_out and out_valid are stable and in_ready = 0.
  - A transfer occurs on an edge where out_valid & out_ready.
  - Output and input transfers in the same cycle are legal and lossless.
- in_ready depends combinationally on out_ready and out_valid only; it never depends on in_valid.
- Timing path per stage: one (DW+LOG2N)-bit adder.

## Structure
- Package hadamard_pkg holds:
  - the clog2-style helper;
  - the OW(DW, LOG2N) width function;
  - the per-stage width function DW+s+1;
  - a lane-index pairing function (i, s) -> partner index.
- Sub-module hadamard_stage (parameters N, IW, S): one registered butterfly layer with valid bit and enable input.
- The top instantiates LOG2N copies in a generate loop and holds the adv/in_ready/out_valid logic.

## Test plan
- Basic (LOG2N=2, DW=8): x = (1,2,3,4), out_ready = 1 → after 2 edges y = (10,-2,-4,0), out_valid for exactly one cycle.
- Extremes: x = (-128,-128,-128,-128) → y = (-512,0,0,0). x = (127,-128,127,-128) → y = (-2,510,0,0). No wrap.
- Streaming: 100 random back-to-back vectors with out_ready = 1 → one result per cycle, in order, each matching the reference model.
- Backpressure: out_ready toggled randomly while in_valid is held high → no vector lost or duplicated; y_out stable while stalled; in_ready = 0 exactly when out_valid & ~out_ready.
- Reset mid-stream: rst_n pulsed low with 2 vectors in flight → out_valid = 0 immediately; after release only newly accepted vectors emerge.
- Size sweep: LOG2N = 1, 3, 6 with DW = 4 and 16, against the reference model.
  - LOG2N=3, x = all ones → y = (8,0,0,0,0,0,0,0).
  - LOG2N=1, x = (5,-3) → y = (2,8).
